// File: rtl/apb_cmd_master.sv
// APB4 master engine: one valid/ready command in, one single APB transfer, one response out.
// Optional read-compare with a saturating error counter is enabled by defining APB_MST_CMP_EN.
module apb_cmd_master #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_strb,
  input  logic [DATA_W-1:0]     cmd_exp,
  input  logic [DATA_W-1:0]     cmd_mask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic                  rsp_mismatch,
  output logic [7:0]            err_cnt,
  output logic                  m_psel,
  output logic                  m_penable,
  output logic                  m_pwrite,
  output logic [ADDR_W-1:0]     m_paddr,
  output logic [DATA_W-1:0]     m_pwdata,
  output logic [DATA_W/8-1:0]   m_pstrb,
  input  logic [DATA_W-1:0]     m_prdata,
  input  logic                  m_pready,
  input  logic                  m_pslverr
);

  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned CntW  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e              state_q, state_d;
  logic                ready_en_q;
  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [StrbW-1:0]    strb_q;
  logic [CntW-1:0]     wait_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                slverr_q;
  logic                timeout_q;
  logic                mismatch_q;
  logic [7:0]          err_cnt_q;
  logic                accept;
  logic                timed_out;
  logic                done;
  logic                cmp_hit;

  assign accept    = cmd_valid && cmd_ready;
  assign timed_out = (TIMEOUT != 0) && !m_pready && (wait_q == CntW'(TIMEOUT - 1));
  assign done      = (state_q == StAccess) && (m_pready || timed_out);

`ifdef APB_MST_CMP_EN
  logic [DATA_W-1:0] exp_q, mask_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      exp_q  <= '0;
      mask_q <= '0;
    end else if (accept) begin
      exp_q  <= cmd_exp;
      mask_q <= cmd_mask;
    end
  end

  assign cmp_hit = m_pready && !write_q && !m_pslverr && (|((m_prdata ^ exp_q) & mask_q));
`else
  logic unused_cmp;
  assign unused_cmp = ^{cmd_exp, cmd_mask};
  assign cmp_hit    = 1'b0;
`endif

  // State register; ready_en_q keeps cmd_ready low until the first edge after reset release.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= StIdle;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (m_pready || timed_out) state_d = StResp;
      StResp:   if (rsp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == StIdle) && ready_en_q;
    m_psel    = (state_q == StSetup) || (state_q == StAccess);
    m_penable = (state_q == StAccess);
    m_pwrite  = m_psel && write_q;
    m_paddr   = m_psel ? addr_q : '0;
    m_pwdata  = m_psel ? wdata_q : '0;
    m_pstrb   = (m_psel && write_q) ? strb_q : '0;
    rsp_valid = (state_q == StResp);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      wait_q  <= '0;
    end else if (accept) begin
      write_q <= cmd_write;
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      strb_q  <= cmd_strb;
      wait_q  <= '0;
    end else if (state_q == StAccess && !done && wait_q != {CntW{1'b1}}) begin
      wait_q  <= wait_q + 1'b1;
    end
  end

  // Response fields only move on RESP entry and stay put while the consumer stalls.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rdata_q    <= '0;
      slverr_q   <= 1'b0;
      timeout_q  <= 1'b0;
      mismatch_q <= 1'b0;
      err_cnt_q  <= '0;
    end else if (done) begin
      rdata_q    <= (m_pready && !write_q) ? m_prdata : '0;
      slverr_q   <= m_pready ? m_pslverr : 1'b1;
      timeout_q  <= !m_pready;
      mismatch_q <= cmp_hit;
      if (cmp_hit && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign rsp_rdata    = rdata_q;
  assign rsp_slverr   = slverr_q;
  assign rsp_timeout  = timeout_q;
  assign rsp_mismatch = mismatch_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

Parametrised APB4 master engine that turns a valid/ready command stream into single APB transfers and returns one response per command. It generalises the write, strobed-write, read and compare sequences used to exercise the timer register file into synthesizable logic. Over today's sequences it adds configurable address and data width, a bounded PREADY wait with timeout abort, and optional hardware read-compare with an error counter. It sits between a command source (on-chip sequencer or debug port) and any APB slave such as `timer_top`.

## Interface
- `ADDR_W`, 12: APB address width, 8..32.
- `DATA_W`, 32: data width; one of 8, 16, 32, 64. Strobe width `DATA_W/8` is derived, not a parameter.
- `TIMEOUT`, 16: maximum ACCESS cycles waiting for PREADY; 0 means wait forever.
- `sys_clk`  in  1  clock; all logic on the rising edge.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  engine can accept a command.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_W  target address.
- `cmd_wdata`  in  DATA_W  write data.
- `cmd_strb`  in  DATA_W/8  byte strobes for writes.
- `cmd_exp`  in  DATA_W  expected read data.
- `cmd_mask`  in  DATA_W  compare mask; 1 = bit checked.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_rdata`  out  DATA_W  captured PRDATA; 0 for writes and timeouts.
- `rsp_slverr`  out  1  PSLVERR seen, or timeout.
- `rsp_timeout`  out  1  transfer aborted by timeout.
- `rsp_mismatch`  out  1  read compare failed.
- `err_cnt`  out  8  saturating count of mismatches.
- `m_psel`, `m_penable`, `m_pwrite`  out  1 each  APB control.
- `m_paddr`  out  ADDR_W  APB address.
- `m_pwdata`  out  DATA_W  APB write data.
- `m_pstrb`  out  DATA_W/8  APB strobes.
- `m_prdata`  in  DATA_W  APB read data.
- `m_pready`, `m_pslverr`  in  1 each  APB completion and error.

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch all `cmd_*` fields and go to SETUP.
- SETUP:
  - `m_psel`=1, `m_penable`=0.
  - Address, data, write and strobe are driven from the latched command.
  - Always advances to ACCESS.
- ACCESS:
  - `m_psel`=1, `m_penable`=1.
  - When `m_pready`=1: capture `m_prdata` (reads only) and `m_pslverr`, then go to RESP.
  - When `TIMEOUT`≠0 and PREADY has stayed low for `TIMEOUT` ACCESS cycles: abort and go to RESP with `rsp_timeout`=1, `rsp_slverr`=1, `rsp_rdata`=0.
- RESP:
  - `rsp_valid`=1 and response fields are held stable.
  - On `rsp_ready`, return to IDLE.
- Outside SETUP and ACCESS, `m_paddr`, `m_pwdata`, `m_pstrb` and `m_pwrite` are 0.
- On reads, `m_pstrb` is forced to 0 regardless of `cmd_strb`.
- Writes with `cmd_strb`=0 are still issued on the bus.
- `m_pwdata` and `m_paddr` are stable from SETUP through the end of ACCESS.
- Wait-cycle counter: `$clog2(TIMEOUT+1)` bits, cleared on SETUP entry, no wrap.
- Reset, including mid-transfer: all outputs go to 0 immediately and state returns to IDLE. A pending response is lost.
- Reset values: every output is 0. `cmd_ready` becomes 1 on the first clock after reset release.

## Timing
- Command accepted at edge N (`cmd_valid`&`cmd_ready`).
- `m_psel` rises after edge N.
- `m_penable` rises after edge N+1.
- With zero wait states, PREADY is sampled at edge N+2; `rsp_valid` rises after edge N+2 and `m_psel`/`m_penable` fall on that same edge.
- Each PREADY wait state adds one cycle.
- With `rsp_ready` tied high, the minimum issue interval is 4 cycles.
- Timeout: aborts at the edge that completes ACCESS cycle `TIMEOUT`. `rsp_valid` rises after edge N+1+`TIMEOUT`.
- `rsp_*` fields change only on RESP entry.
- `err_cnt` updates on the same edge as RESP entry.

## Configuration
- `APB_MST_CMP_EN` defined:
  - On a completed read without PSLVERR or timeout, `rsp_mismatch` = |((prdata ^ cmd_exp) & cmd_mask).
  - Each mismatch increments `err_cnt`, saturating at 255.
  - `err_cnt` is cleared only by reset.
- Undefined: compare logic is removed; `rsp_mismatch` and `err_cnt` are tied to 0 and `cmd_exp`/`cmd_mask` are ignored. Ports are kept in both builds.

## Test plan
- Write 0x00000100 to addr 0x00, strb 0xF, zero-wait slave:
  - `m_psel` high 2 cycles, `m_pstrb`=0xF.
  - `rsp_valid` 3 cycles after accept, `rsp_slverr`=0, `rsp_rdata`=0.
- Read addr 0x1C, slave returns 0x00000001 after 2 wait states:
  - `rsp_rdata`=0x00000001 after 5 cycles.
  - `m_pstrb`=0 throughout.
- Strobed write: data 0xAABBCCDD, strb 0x5 → `m_pstrb`=0x5 during SETUP and ACCESS.
- Read addr 0xFFC with the slave asserting PSLVERR → `rsp_slverr`=1, `rsp_timeout`=0.
- `TIMEOUT`=4, PREADY held low:
  - Abort after 4 ACCESS cycles with `rsp_timeout`=1 and `rsp_slverr`=1.
  - Next command is accepted normally.
- With `APB_MST_CMP_EN`:
  - Read returns 0x12345678 with exp 0x12340000, mask 0xFFFF0000 → `rsp_mismatch`=0.
  - Same read with mask 0xFFFFFFFF → `rsp_mismatch`=1, `err_cnt`=1.
  - Assert reset mid-ACCESS → `m_psel` drops immediately and `err_cnt`=0.
